dtc_sched: RTL

DTC_SCHED -- requirements
Module: dtc_sched

---
 rtl/dtc_sched.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dtc_sched.sv
// Round-robin scheduler sharing one DTC among NREQ requesters: grants a request,
// triggers the DTC, measures the returned pulse width and reports it on done.
//
// state | meaning
// IDLE  | waiting for en and a valid request; grant happens here
// TRIG  | one-cycle dtc_trig, width counter cleared, timer loaded
// RUN   | dtc_val+2 cycles sampling dtc_pulse into the width counter
// DONE  | one-cycle done strobe with id, width and error flag
module dtc_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic [NREQ-1:0]                        req_valid,
  input  logic [NREQ*W-1:0]                      req_data,
  output logic [NREQ-1:0]                        req_ready,
  output logic                                   dtc_trig,
  output logic [W-1:0]                           dtc_val,
  input  logic                                   dtc_pulse,
  output logic                                   done,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] done_id,
  output logic [W:0]                             done_width,
  output logic                                   done_err,
  output logic                                   busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] cur_id;
  logic [W:0]     timer;
  logic [W:0]     wcnt;
  logic [W:0]     wcnt_nxt;
  logic [IDW-1:0] winner;
  logic           found;
  logic           grant;
  int             idx_i;

  // Search upward with wrap starting just after the last completed requester.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx_i  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_i = (int'(last_grant) + k) % NREQ;
      if (!found && req_valid[idx_i]) begin
        found  = 1'b1;
        winner = IDW'(idx_i);
      end
    end
  end

  // Gated by rst so no accept strobe is seen while reset is held.
  assign grant = rst && en && (state == IDLE) && found;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  always_comb begin
    wcnt_nxt = wcnt;
    if (dtc_pulse && (wcnt != {(W+1){1'b1}})) wcnt_nxt = wcnt + (W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      cur_id     <= '0;
      timer      <= '0;
      wcnt       <= '0;
      dtc_trig   <= 1'b0;
      dtc_val    <= '0;
      done       <= 1'b0;
      done_id    <= '0;
      done_width <= '0;
      done_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            dtc_val  <= req_data[int'(winner)*W +: W];
            cur_id   <= winner;
            dtc_trig <= 1'b1;
            busy     <= 1'b1;
            state    <= TRIG;
          end
        end
        TRIG: begin
          dtc_trig <= 1'b0;
          wcnt     <= '0;
          timer    <= {1'b0, dtc_val} + (W+1)'(1);
          state    <= RUN;
        end
        RUN: begin
          wcnt <= wcnt_nxt;
          if (timer == '0) begin
            done       <= 1'b1;
            done_id    <= cur_id;
            done_width <= wcnt_nxt;
            done_err   <= (wcnt_nxt != {1'b0, dtc_val});
            state      <= DONE;
          end else begin
            timer <= timer - (W+1)'(1);
          end
        end
        DONE: begin
          done       <= 1'b0;
          done_id    <= '0;
          done_width <= '0;
          done_err   <= 1'b0;
          busy       <= 1'b0;
          last_grant <= cur_id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
